decoder_2_to_4: RTL and testbench

- Binary 2-to-4 one-hot decoder with a registered output stage.
- Converts a 2-bit select code into a 4-bit one-hot word where bit N is set when the input equals N.
- Used as a select/enable generator for 4-way resources such as bank selects and chip selects.
- An enable input gates decoding; a valid flag qualifies the output.

---
 rtl/decoder_2_to_4.sv | 76 +++++++
 tb/tb_decoder_2_to_4.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/decoder_2_to_4.sv
// 2-to-4 one-hot decoder with decode enable, selectable output polarity and an
// optional output register stage (1-cycle latency) with asynchronous reset.
module decoder_2_to_4 #(
    parameter bit ACTIVE_LOW = 1'b0,
    parameter bit REG_OUT    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] de_in,
    output logic [3:0] de_out,
    output logic       de_valid
);

    // XOR mask applied to the active-high word; also the word shown when idle.
    localparam logic [3:0] POL_MASK      = ACTIVE_LOW ? 4'b1111 : 4'b0000;
    localparam logic [3:0] INACTIVE_WORD = POL_MASK;

    // An unknown select code yields all-X rather than a plausible one-hot word.
    function automatic logic [3:0] decode_onehot(input logic [1:0] code);
        logic [3:0] word;
        case (code)
            2'b00:   word = 4'b0001;
            2'b01:   word = 4'b0010;
            2'b10:   word = 4'b0100;
            2'b11:   word = 4'b1000;
            default: word = 4'bxxxx;
        endcase
        return word;
    endfunction

    logic [3:0] w_word_s;
    logic       w_valid_s;

    // Decode stage shared by the registered and combinational variants
    always_comb begin
        w_word_s  = INACTIVE_WORD;
        w_valid_s = 1'b0;
        if (en) begin
            w_word_s  = decode_onehot(de_in) ^ POL_MASK;
            w_valid_s = 1'b1;
        end else begin
            w_word_s  = INACTIVE_WORD;
            w_valid_s = 1'b0;
        end
    end

    generate
        if (REG_OUT) begin : g_reg
            logic [3:0] r_word_r;
            logic       r_valid_r;

            // Output register; reset forces the idle word and drops any pending decode
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_word_r  <= INACTIVE_WORD;
                    r_valid_r <= 1'b0;
                end else begin
                    r_word_r  <= w_word_s;
                    r_valid_r <= w_valid_s;
                end
            end

            assign de_out   = r_word_r;
            assign de_valid = r_valid_r;
        end else begin : g_comb
            // Clock and reset play no part in the zero-latency variant.
            logic w_unused_s;
            assign w_unused_s = clk ^ rst_n;

            assign de_out   = w_word_s;
            assign de_valid = w_valid_s;
        end
    endgenerate

endmodule

// File: tb/tb_decoder_2_to_4.sv
// Self-checking bench for decoder_2_to_4: directed literal vectors plus a
// per-cycle comparison against a shift-based reference model.
module tb_decoder_2_to_4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       en    = 1'b1;
    logic [1:0] de_in = 2'b10;

    logic [3:0] out_hi, out_lo, out_cb;
    logic       val_hi, val_lo, val_cb;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    decoder_2_to_4 #(.ACTIVE_LOW(1'b0), .REG_OUT(1'b1)) dut_hi (
        .clk(clk), .rst_n(rst_n), .en(en), .de_in(de_in),
        .de_out(out_hi), .de_valid(val_hi)
    );

    decoder_2_to_4 #(.ACTIVE_LOW(1'b1), .REG_OUT(1'b1)) dut_lo (
        .clk(clk), .rst_n(rst_n), .en(en), .de_in(de_in),
        .de_out(out_lo), .de_valid(val_lo)
    );

    decoder_2_to_4 #(.ACTIVE_LOW(1'b0), .REG_OUT(1'b0)) dut_cb (
        .clk(clk), .rst_n(rst_n), .en(en), .de_in(de_in),
        .de_out(out_cb), .de_valid(val_cb)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the registered word is 1 shifted by the sampled code.
    logic [3:0] m_word;
    logic       m_valid;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_word  <= 4'b0000;
            m_valid <= 1'b0;
        end else begin
            m_valid <= (en === 1'b1);
            m_word  <= (en === 1'b1) ? (4'b0001 << de_in) : 4'b0000;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_word_hi", out_hi, m_word);
            check("model_valid_hi", {3'b000, val_hi}, {3'b000, m_valid});
            check("model_word_lo", out_lo, ~m_word);
            check("model_valid_lo", {3'b000, val_lo}, {3'b000, m_valid});
            check("model_word_comb", out_cb, (en === 1'b1) ? (4'b0001 << de_in) : 4'b0000);
            check("model_valid_comb", {3'b000, val_cb}, {3'b000, en});
            if (val_hi === 1'b1)
                check("onehot_hi", {3'b000, $onehot(out_hi)}, 4'b0001);
        end
    end

    // Directed vectors: en, code, expected word (active-high), expected valid
    logic       v_en   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [1:0] v_code [7] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01};
    logic [3:0] v_exp  [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b0000, 4'b0010};
    logic [3:0] v_expl [7] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b0111, 4'b1111, 4'b1101};
    logic       v_val  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        #1 rst_n = 1'b0;

        // Reset held with clock running and en=1, de_in=10
        repeat (3) @(posedge clk);
        #1;
        check("rst_word_hi", out_hi, 4'b0000);
        check("rst_valid_hi", {3'b000, val_hi}, 4'b0000);
        check("rst_word_lo", out_lo, 4'b1111);
        chk_on = 1'b1;

        // Release between edges; the first edge decodes normally
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_word", out_hi, 4'b0100);
        check("post_rst_valid", {3'b000, val_hi}, 4'b0001);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_word_hi", out_hi, 4'b0000);
        check("async_rst_valid", {3'b000, val_hi}, 4'b0000);
        check("async_rst_word_lo", out_lo, 4'b1111);
        #1 rst_n = 1'b1;

        // Back-to-back directed vectors; each checked one edge after it is applied
        for (int i = 0; i <= 7; i++) begin
            @(posedge clk);
            #1;
            if (i > 0) begin
                check("dir_word_hi", out_hi, v_exp[i-1]);
                check("dir_valid_hi", {3'b000, val_hi}, {3'b000, v_val[i-1]});
                check("dir_word_lo", out_lo, v_expl[i-1]);
            end
            #1;
            if (i < 7) begin
                en    = v_en[i];
                de_in = v_code[i];
                #1;
                check("dir_word_comb", out_cb, v_exp[i]);
            end
        end

        // Zero-latency variant held without relying on any clock edge
        for (int c = 0; c < 4; c++) begin
            en    = 1'b1;
            de_in = 2'(c);
            #1;
            check("comb_same_step", out_cb, 4'b0001 << c);
        end

        // Random regression with occasional mid-cycle reset pulses
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk);
            #2;
            en    = 1'($urandom_range(0, 3) != 0);
            de_in = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) begin
                #1 rst_n = 1'b0;
                #1;
                check("rand_rst_word_hi", out_hi, 4'b0000);
                check("rand_rst_word_lo", out_lo, 4'b1111);
                #2 rst_n = 1'b1;
            end
        end

        @(posedge clk);
        @(negedge clk);
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
